// File: rtl/pwm_gen.sv
// ----------------------------------------------------------------------------
// pwm_gen : multi-channel PWM waveform generator
//
// Receives per-channel configuration writes (enable, period, high-level length)
// from the PWM parameter parser and drives one registered PWM output per
// channel. Each channel keeps a shadow set (written by the config port), an
// active set (driving the waveform) and a free-running 28-bit period counter.
//
// Optional feature macro: PWM_GLITCHLESS_UPDATE_EN
//   defined   : a running channel moves shadow -> active only at its period
//               boundary, so the current period always completes.
//   undefined : shadow -> active happens one cycle after every write and the
//               counter restarts (current period truncated).
//
// Parameters
//   CHANNEL_NUM         number of channels (1..256)
//
// Ports
//   clk                 in   module clock
//   rst                 in   synchronous reset, active-high
//   pwm_config_vld      in   1-cycle config write strobe
//   pwm_config_channel  in   [7:0]  target channel index
//   pwm_en              in   channel output enable
//   pwm_period          in   [27:0] period length in clk cycles
//   pwm_hlevel          in   [27:0] high-level length in clk cycles
//   pwm_out             out  [CHANNEL_NUM-1:0] PWM waveforms, registered
//   pwm_pending         out  [CHANNEL_NUM-1:0] shadow written, not yet applied
// ----------------------------------------------------------------------------
module pwm_gen #(
    parameter int CHANNEL_NUM = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pwm_config_vld,
    input  logic [7:0]             pwm_config_channel,
    input  logic                   pwm_en,
    input  logic [27:0]            pwm_period,
    input  logic [27:0]            pwm_hlevel,
    output logic [CHANNEL_NUM-1:0] pwm_out,
    output logic [CHANNEL_NUM-1:0] pwm_pending
);

    for (genvar ch = 0; ch < CHANNEL_NUM; ch++) begin : g_ch
        logic        sh_en_q, sh_en_d;
        logic [27:0] sh_period_q, sh_period_d;
        logic [27:0] sh_hlevel_q, sh_hlevel_d;
        logic        act_en_q, act_en_d;
        logic [27:0] act_period_q, act_period_d;
        logic [27:0] act_hlevel_q, act_hlevel_d;
        logic [27:0] cnt_q, cnt_d;
        logic        pend_q, pend_d;
        logic        out_q, out_d;
        logic        wr, running, boundary, load;

        // Indices >= CHANNEL_NUM never match any instance, so such writes
        // are dropped without touching state.
        assign wr       = pwm_config_vld && (pwm_config_channel == 8'(ch));
        assign running  = act_en_q && (act_period_q != 28'd0);
        assign boundary = (cnt_q == act_period_q - 28'd1);

`ifdef PWM_GLITCHLESS_UPDATE_EN
        // Idle channels load at once; running ones wait for the last count
        // of the period so no runt pulse is produced.
        assign load = pend_q && (!running || boundary);
`else
        assign load = pend_q;
`endif

        always_comb begin
            sh_en_d      = sh_en_q;
            sh_period_d  = sh_period_q;
            sh_hlevel_d  = sh_hlevel_q;
            act_en_d     = act_en_q;
            act_period_d = act_period_q;
            act_hlevel_d = act_hlevel_q;
            pend_d       = pend_q;

            // Load uses the shadow as it was before any write on this edge.
            if (load) begin
                act_en_d     = sh_en_q;
                act_period_d = sh_period_q;
                act_hlevel_d = sh_hlevel_q;
                cnt_d        = '0;
                pend_d       = 1'b0;
            end else if (running) begin
                cnt_d = boundary ? '0 : cnt_q + 28'd1;
            end else begin
                cnt_d = '0;
            end

            // A write coinciding with a load keeps pending set for the new data.
            if (wr) begin
                sh_en_d     = pwm_en;
                sh_period_d = pwm_period;
                sh_hlevel_d = pwm_hlevel;
                pend_d      = 1'b1;
            end

            // hlevel >= period gives constant high because cnt < period.
            out_d = running && (cnt_q < act_hlevel_q);
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                sh_en_q      <= 1'b0;
                sh_period_q  <= '0;
                sh_hlevel_q  <= '0;
                act_en_q     <= 1'b0;
                act_period_q <= '0;
                act_hlevel_q <= '0;
                cnt_q        <= '0;
                pend_q       <= 1'b0;
                out_q        <= 1'b0;
            end else begin
                sh_en_q      <= sh_en_d;
                sh_period_q  <= sh_period_d;
                sh_hlevel_q  <= sh_hlevel_d;
                act_en_q     <= act_en_d;
                act_period_q <= act_period_d;
                act_hlevel_q <= act_hlevel_d;
                cnt_q        <= cnt_d;
                pend_q       <= pend_d;
                out_q        <= out_d;
            end
        end

        assign pwm_out[ch]     = out_q;
        assign pwm_pending[ch] = pend_q;
    end

endmodule

// File: tb/tb_pwm_gen.sv
module tb_pwm_gen;
    localparam int CHANNEL_NUM = 8;
`ifdef PWM_GLITCHLESS_UPDATE_EN
    localparam bit GL = 1'b1;
`else
    localparam bit GL = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   pwm_config_vld = 1'b0;
    logic [7:0]             pwm_config_channel = '0;
    logic                   pwm_en = 1'b0;
    logic [27:0]            pwm_period = '0;
    logic [27:0]            pwm_hlevel = '0;
    logic [CHANNEL_NUM-1:0] pwm_out;
    logic [CHANNEL_NUM-1:0] pwm_pending;

    pwm_gen #(.CHANNEL_NUM(CHANNEL_NUM)) dut (
        .clk                (clk),
        .rst                (rst),
        .pwm_config_vld     (pwm_config_vld),
        .pwm_config_channel (pwm_config_channel),
        .pwm_en             (pwm_en),
        .pwm_period         (pwm_period),
        .pwm_hlevel         (pwm_hlevel),
        .pwm_out            (pwm_out),
        .pwm_pending        (pwm_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] out;
        logic [7:0] pend;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // Waveform of a channel whose counter started so that its first high
    // cycle (if any) is at cycle 'start'.
    function automatic bit pat(input int c, input int start, input int per, input int hl);
        return (c >= start) && (((c - start) % per) < hl);
    endfunction

    task automatic drive(input int ch, input bit en, input int per, input int hl);
        pwm_config_vld     = 1'b1;
        pwm_config_channel = ch[7:0];
        pwm_en             = en;
        pwm_period         = per[27:0];
        pwm_hlevel         = hl[27:0];
    endtask

    task automatic apply_reset();
        @(negedge clk);
        pwm_config_vld = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        apply_reset();
        for (int k = 0; k < 50; k++) begin
            e.out = 8'h00; e.pend = 8'h00;
            sb.push_back(e);
        end
        for (int k = 0; k < 50; k++) begin
            e = sb.pop_front();
            checks++;
            if (pwm_out !== e.out || pwm_pending !== e.pend) begin
                errors++;
                $display("FAIL reset cyc=%0d out=%b pend=%b expected out=%b pend=%b",
                         k, pwm_out, pwm_pending, e.out, e.pend);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_basic();
        exp_t e;
        apply_reset();
        drive(0, 1'b1, 10, 3);
        for (int k = 1; k <= 32; k++) begin
            e.out  = {7'b0, pat(k, 3, 10, 3)};
            e.pend = (k == 1) ? 8'h01 : 8'h00;
            sb.push_back(e);
        end
        @(negedge clk);
        for (int k = 1; k <= 32; k++) begin
            pwm_config_vld = 1'b0;
            e = sb.pop_front();
            checks++;
            if (pwm_out !== e.out || pwm_pending !== e.pend) begin
                errors++;
                $display("FAIL basic cyc=%0d out=%b pend=%b expected out=%b pend=%b",
                         k, pwm_out, pwm_pending, e.out, e.pend);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_levels();
        exp_t e;
        int   hls[3] = '{0, 10, 15};
        for (int t = 0; t < 3; t++) begin
            apply_reset();
            drive(0, 1'b1, 10, hls[t]);
            for (int k = 1; k <= 20; k++) begin
                e.out  = {7'b0, pat(k, 3, 10, hls[t])};
                e.pend = (k == 1) ? 8'h01 : 8'h00;
                sb.push_back(e);
            end
            @(negedge clk);
            for (int k = 1; k <= 20; k++) begin
                pwm_config_vld = 1'b0;
                e = sb.pop_front();
                checks++;
                if (pwm_out !== e.out || pwm_pending !== e.pend) begin
                    errors++;
                    $display("FAIL levels hl=%0d cyc=%0d out=%b pend=%b expected out=%b pend=%b",
                             hls[t], k, pwm_out, pwm_pending, e.out, e.pend);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_update();
        exp_t e;
        bit   o;
        apply_reset();
        drive(0, 1'b1, 10, 3);
        for (int k = 1; k <= 50; k++) begin
            if (GL) o = (k <= 22) ? pat(k, 3, 10, 3) : pat(k, 23, 10, 6);
            else    o = (k <= 19) ? pat(k, 3, 10, 3) : pat(k, 20, 10, 6);
            e.out  = {7'b0, o};
            e.pend = ((k == 1) || (GL ? (k >= 18 && k <= 21) : (k == 18))) ? 8'h01 : 8'h00;
            sb.push_back(e);
        end
        @(negedge clk);
        for (int k = 1; k <= 50; k++) begin
            pwm_config_vld = 1'b0;
            if (k == 17) drive(0, 1'b1, 10, 6);   // counter is at 5 here
            e = sb.pop_front();
            checks++;
            if (pwm_out !== e.out || pwm_pending !== e.pend) begin
                errors++;
                $display("FAIL update cyc=%0d out=%b pend=%b expected out=%b pend=%b",
                         k, pwm_out, pwm_pending, e.out, e.pend);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bit   o, p;
        apply_reset();
        drive(3, 1'b1, 10, 3);
        for (int k = 1; k <= 30; k++) begin
            if (GL) begin
                o = (k <= 12) ? pat(k, 3, 10, 3) : pat(k, 13, 4, 1);
                p = (k >= 1 && k <= 11);
            end else begin
                o = (k <= 3) ? pat(k, 3, 10, 3) : pat(k, 4, 4, 1);
                p = (k == 1 || k == 2);
            end
            e.out  = {4'b0, o, 3'b0};
            e.pend = {4'b0, p, 3'b0};
            sb.push_back(e);
        end
        @(negedge clk);
        for (int k = 1; k <= 30; k++) begin
            pwm_config_vld = 1'b0;
            if (k == 1) drive(3, 1'b1, 4, 1);
            e = sb.pop_front();
            checks++;
            if (pwm_out !== e.out || pwm_pending !== e.pend) begin
                errors++;
                $display("FAIL back_to_back cyc=%0d out=%b pend=%b expected out=%b pend=%b",
                         k, pwm_out, pwm_pending, e.out, e.pend);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_out_of_range();
        exp_t e;
        apply_reset();
        drive(0, 1'b1, 10, 3);
        for (int k = 1; k <= 40; k++) begin
            e.out  = {7'b0, pat(k, 3, 10, 3)};
            e.pend = (k == 1) ? 8'h01 : 8'h00;
            sb.push_back(e);
        end
        @(negedge clk);
        for (int k = 1; k <= 40; k++) begin
            pwm_config_vld = 1'b0;
            if (k == 10) drive(CHANNEL_NUM, 1'b1, 4, 2);
            if (k == 12) drive(255, 1'b1, 4, 2);
            e = sb.pop_front();
            checks++;
            if (pwm_out !== e.out || pwm_pending !== e.pend) begin
                errors++;
                $display("FAIL out_of_range cyc=%0d out=%b pend=%b expected out=%b pend=%b",
                         k, pwm_out, pwm_pending, e.out, e.pend);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_independent();
        exp_t e;
        bit   o1, p1, o2, p2;
        apply_reset();
        drive(1, 1'b1, 8, 2);
        for (int k = 1; k <= 50; k++) begin
            if (GL) begin
                o1 = (k <= 26) ? pat(k, 3, 8, 2) : 1'b0;
                p1 = (k == 1) || (k >= 18 && k <= 25);
            end else begin
                o1 = (k <= 19) ? pat(k, 3, 8, 2) : 1'b0;
                p1 = (k == 1) || (k == 18);
            end
            o2 = pat(k, 4, 5, 5);
            p2 = (k == 2);
            if (k >= 41) begin
                o1 = 1'b0; p1 = 1'b0; o2 = 1'b0; p2 = 1'b0;
            end
            e.out  = {5'b0, o2, o1, 1'b0};
            e.pend = {5'b0, p2, p1, 1'b0};
            sb.push_back(e);
        end
        @(negedge clk);
        for (int k = 1; k <= 50; k++) begin
            pwm_config_vld = 1'b0;
            if (k == 1)  drive(2, 1'b1, 5, 5);
            if (k == 17) drive(1, 1'b0, 8, 2);    // ch1 counter at 7 here
            rst = (k == 40);
            e = sb.pop_front();
            checks++;
            if (pwm_out !== e.out || pwm_pending !== e.pend) begin
                errors++;
                $display("FAIL independent cyc=%0d out=%b pend=%b expected out=%b pend=%b",
                         k, pwm_out, pwm_pending, e.out, e.pend);
            end
            @(negedge clk);
        end
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_levels();
        test_update();
        test_back_to_back();
        test_out_of_range();
        test_independent();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
